// File: rtl/hp35_display_scan.sv
// HP-35 display bus capture and multiplexed LED scan: frames of 14 BCD digits
// arrive serially on DD, are committed atomically, and are scanned one digit per dwell.
module hp35_display_scan #(
   parameter int DWELL = 256,
   parameter int BLANK = 4
) (
   input  logic        osc_in,
   input  logic        cdiv_rst,
   input  logic        phi2,
   input  logic        START,
   input  logic [4:0]  DD,
   input  logic        display_en,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [13:0] dig_sel,
   output logic        frame_done,
   output logic        frame_err,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(DWELL);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] COMMIT  = 2'd2;

   logic          phi2_s1, phi2_s2, phi2_prev;
   logic          start_s1, start_s2;
   logic [4:0]    dd_s1, dd_s2;
   logic          tick;

   logic [1:0]    state;
   logic [1:0]    bitcnt;
   logic [3:0]    digcnt;
   logic [4:0]    shadow [14];
   logic [4:0]    buffer [14];

   logic [CW-1:0] scan_cnt;
   logic [3:0]    scan_idx;
   logic [4:0]    cur_digit;
   logic          show;

   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hE:    s = 7'h40;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Input synchronizers; phi2_prev turns the synchronized phi2 into a one-cycle tick
   always_ff @(posedge osc_in or posedge cdiv_rst) begin
      if (cdiv_rst) begin
         phi2_s1   <= 1'b0;
         phi2_s2   <= 1'b0;
         phi2_prev <= 1'b0;
         start_s1  <= 1'b0;
         start_s2  <= 1'b0;
         dd_s1     <= 5'h00;
         dd_s2     <= 5'h00;
      end else begin
         phi2_s1   <= phi2;
         phi2_s2   <= phi2_s1;
         phi2_prev <= phi2_s2;
         start_s1  <= START;
         start_s2  <= start_s1;
         dd_s1     <= DD;
         dd_s2     <= dd_s1;
      end
   end

   assign tick      = phi2_s2 & ~phi2_prev;
   assign dbg_state = state;

   always_ff @(posedge osc_in or posedge cdiv_rst) begin
      if (cdiv_rst) begin
         state      <= IDLE;
         bitcnt     <= 2'd0;
         digcnt     <= 4'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         for (int i = 0; i < 14; i++) shadow[i] <= 5'h0F;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tick && start_s2) begin
                  state  <= CAPTURE;
                  bitcnt <= 2'd0;
                  digcnt <= 4'd0;
               end
            end
            CAPTURE: begin
               if (tick) begin
                  // A new START mid-frame wins over any data on the same tick
                  if (start_s2) begin
                     frame_err <= 1'b1;
                     bitcnt    <= 2'd0;
                     digcnt    <= 4'd0;
                  end else begin
                     bitcnt <= bitcnt + 2'd1;
                     if (bitcnt == 2'd3) begin
                        shadow[digcnt] <= dd_s2;
                        digcnt         <= digcnt + 4'd1;
                        if (digcnt == 4'd13) state <= COMMIT;
                     end
                  end
               end
            end
            COMMIT: begin
               frame_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge osc_in or posedge cdiv_rst) begin
      if (cdiv_rst) begin
         for (int i = 0; i < 14; i++) buffer[i] <= 5'h0F;
      end else if (state == COMMIT) begin
         buffer <= shadow;
      end
   end

   // Free-running scan, untouched by capture activity
   always_ff @(posedge osc_in or posedge cdiv_rst) begin
      if (cdiv_rst) begin
         scan_cnt <= '0;
         scan_idx <= 4'd0;
      end else if (scan_cnt == CW'(DWELL - 1)) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == 4'd13) ? 4'd0 : scan_idx + 4'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign cur_digit = buffer[scan_idx];
   assign show      = display_en && (scan_cnt >= CW'(BLANK));

   always_ff @(posedge osc_in or posedge cdiv_rst) begin
      if (cdiv_rst) begin
         seg     <= 7'h00;
         dp      <= 1'b0;
         dig_sel <= 14'h0000;
      end else if (show) begin
         seg     <= seg_decode(cur_digit[3:0]);
         dp      <= cur_digit[4];
         dig_sel <= 14'h0001 << scan_idx;
      end else begin
         seg     <= 7'h00;
         dp      <= 1'b0;
         dig_sel <= 14'h0000;
      end
   end

endmodule

// File: tb/tb_hp35_display_scan.sv
// Directed bench for hp35_display_scan with a short dwell so full scans stay quick.
module tb_hp35_display_scan;

   logic        osc_in = 1'b0;
   logic        cdiv_rst;
   logic        phi2;
   logic        START;
   logic [4:0]  DD;
   logic        display_en;
   logic [6:0]  seg;
   logic        dp;
   logic [13:0] dig_sel;
   logic        frame_done;
   logic        frame_err;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int pre_done = 0;

   logic [4:0] frame   [14];
   logic [6:0] exp_seg [14];
   logic       exp_dp  [14];

   hp35_display_scan #(.DWELL(16), .BLANK(4)) dut (
      .osc_in     (osc_in),
      .cdiv_rst   (cdiv_rst),
      .phi2       (phi2),
      .START      (START),
      .DD         (DD),
      .display_en (display_en),
      .seg        (seg),
      .dp         (dp),
      .dig_sel    (dig_sel),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .dbg_state  (dbg_state)
   );

   always #5 osc_in = ~osc_in;

   always @(negedge osc_in) if (frame_done === 1'b1) done_cnt++;

   task automatic send_tick(input logic st, input logic [4:0] d);
      @(negedge osc_in);
      START = st;
      DD    = d;
      phi2  = 1'b1;
      repeat (3) @(negedge osc_in);
      phi2 = 1'b0;
      repeat (3) @(negedge osc_in);
   endtask

   // START tick, then four bit times per digit; DD is captured on the fourth
   task automatic send_frame();
      send_tick(1'b1, 5'h0F);
      for (int k = 0; k < 14; k++) begin
         for (int b = 0; b < 4; b++) begin
            if (k == 13 && b == 3) pre_done = done_cnt;
            send_tick(1'b0, frame[k]);
         end
      end
      repeat (3) @(negedge osc_in);
   endtask

   task automatic check_scan(input string tag);
      for (int i = 0; i < 14; i++) begin
         int w;
         w = 0;
         while (dig_sel !== (14'h0001 << i) && w < 600) begin
            @(negedge osc_in);
            w++;
         end
         n_checks++;
         if (dig_sel !== (14'h0001 << i)) begin
            n_fail++;
            $display("FAIL %s_sel%0d dig_sel=%h required=%h", tag, i, dig_sel, 14'h0001 << i);
         end else if (seg !== exp_seg[i] || dp !== exp_dp[i]) begin
            n_fail++;
            $display("FAIL %s_digit%0d seg=%h dp=%b required seg=%h dp=%b",
                     tag, i, seg, dp, exp_seg[i], exp_dp[i]);
         end
      end
   endtask

   task automatic test_reset();
      cdiv_rst = 1'b1; phi2 = 1'b0; START = 1'b0; DD = 5'h00; display_en = 1'b1;
      repeat (4) @(negedge osc_in);
      n_checks++;
      if ({seg, dp, dig_sel, frame_done, frame_err, dbg_state} !== 26'h0) begin
         n_fail++;
         $display("FAIL reset_outputs seg=%h dp=%b sel=%h done=%b err=%b st=%0d required all 0",
                  seg, dp, dig_sel, frame_done, frame_err, dbg_state);
      end
      @(negedge osc_in) cdiv_rst = 1'b0;
      for (int i = 0; i < 14; i++) begin exp_seg[i] = 7'h00; exp_dp[i] = 1'b0; end
      check_scan("reset_blank");
      n_checks++;
      if (dbg_state !== 2'd0 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle st=%0d err=%b required 0 0", dbg_state, frame_err);
      end
   endtask

   task automatic test_full_frame();
      int base;
      frame   = '{5'h01, 5'h02, 5'h13, 5'h04, 5'h05, 5'h06, 5'h07,
                  5'h08, 5'h09, 5'h00, 5'h0E, 5'h0F, 5'h03, 5'h04};
      exp_seg = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h3F, 7'h40, 7'h00, 7'h4F, 7'h66};
      exp_dp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      base = done_cnt;
      send_tick(1'b1, 5'h0F);
      n_checks++;
      if (dbg_state !== 2'd1) begin
         n_fail++;
         $display("FAIL capture_state st=%0d required 1", dbg_state);
      end
      for (int k = 0; k < 14; k++)
         for (int b = 0; b < 4; b++) begin
            if (k == 13 && b == 3) pre_done = done_cnt;
            send_tick(1'b0, frame[k]);
         end
      repeat (3) @(negedge osc_in);
      n_checks++;
      if (pre_done !== base) begin
         n_fail++;
         $display("FAIL early_done count=%0d required %0d before tick 56", pre_done - base, 0);
      end
      n_checks++;
      if (done_cnt !== base + 1) begin
         n_fail++;
         $display("FAIL frame_done_count count=%0d required 1", done_cnt - base);
      end
      n_checks++;
      if (frame_err !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL frame_status err=%b st=%0d required 0 0", frame_err, dbg_state);
      end
      check_scan("full_frame");
   endtask

   task automatic test_scan_timing();
      logic [13:0] targets [2];
      logic [13:0] nexts   [2];
      targets = '{14'h0001, 14'h2000};
      nexts   = '{14'h0002, 14'h0001};
      for (int t = 0; t < 2; t++) begin
         int w, hi, lo;
         logic blank_ok;
         w = 0;
         while (dig_sel === targets[t] && w < 600) begin @(negedge osc_in); w++; end
         while (dig_sel !== targets[t] && w < 600) begin @(negedge osc_in); w++; end
         hi = 0;
         while (dig_sel === targets[t] && hi < 40) begin hi++; @(negedge osc_in); end
         lo = 0;
         blank_ok = 1'b1;
         while (dig_sel === 14'h0 && lo < 40) begin
            if (seg !== 7'h00 || dp !== 1'b0) blank_ok = 1'b0;
            lo++;
            @(negedge osc_in);
         end
         n_checks++;
         if (hi !== 12) begin
            n_fail++;
            $display("FAIL dwell_high%0d cycles=%0d required 12", t, hi);
         end
         n_checks++;
         if (lo !== 4 || !blank_ok) begin
            n_fail++;
            $display("FAIL blank_gap%0d cycles=%0d clean=%b required 4 1", t, lo, blank_ok);
         end
         n_checks++;
         if (dig_sel !== nexts[t]) begin
            n_fail++;
            $display("FAIL scan_next%0d dig_sel=%h required %h", t, dig_sel, nexts[t]);
         end
      end
   endtask

   task automatic test_abort();
      int base;
      base = done_cnt;
      send_tick(1'b1, 5'h0F);
      for (int i = 0; i < 20; i++) send_tick(1'b0, 5'h08);
      frame   = '{5'h09, 5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03,
                  5'h02, 5'h01, 5'h00, 5'h0C, 5'h0E, 5'h01, 5'h12};
      exp_seg = '{7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F,
                  7'h5B, 7'h06, 7'h3F, 7'h00, 7'h40, 7'h06, 7'h5B};
      exp_dp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      send_frame();
      n_checks++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_err frame_err=%b required 1", frame_err);
      end
      n_checks++;
      if (done_cnt !== base + 1) begin
         n_fail++;
         $display("FAIL abort_done count=%0d required 1", done_cnt - base);
      end
      check_scan("abort");
   endtask

   task automatic test_display_en();
      int base;
      logic quiet;
      base = done_cnt;
      display_en = 1'b0;
      frame   = '{5'h07, 5'h0E, 5'h00, 5'h05, 5'h0D, 5'h11, 5'h09,
                  5'h04, 5'h0A, 5'h06, 5'h0B, 5'h02, 5'h08, 5'h03};
      exp_seg = '{7'h07, 7'h40, 7'h3F, 7'h6D, 7'h00, 7'h06, 7'h6F,
                  7'h66, 7'h00, 7'h7D, 7'h00, 7'h5B, 7'h7F, 7'h4F};
      exp_dp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      quiet = 1'b1;
      fork
         send_frame();
         for (int c = 0; c < 330; c++) begin
            @(negedge osc_in);
            if (seg !== 7'h00 || dp !== 1'b0 || dig_sel !== 14'h0) quiet = 1'b0;
         end
      join
      n_checks++;
      if (!quiet) begin
         n_fail++;
         $display("FAIL disabled_outputs nonzero seen=%b required 0", !quiet);
      end
      n_checks++;
      if (done_cnt !== base + 1) begin
         n_fail++;
         $display("FAIL disabled_done count=%0d required 1", done_cnt - base);
      end
      display_en = 1'b1;
      check_scan("enable");
   endtask

   task automatic test_reset_mid_capture();
      int base;
      send_tick(1'b1, 5'h0F);
      for (int i = 0; i < 28; i++) send_tick(1'b0, 5'h08);
      @(negedge osc_in) cdiv_rst = 1'b1;
      repeat (2) @(negedge osc_in);
      n_checks++;
      if ({seg, dp, dig_sel, frame_done, frame_err, dbg_state} !== 26'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs seg=%h dp=%b sel=%h done=%b err=%b st=%0d required all 0",
                  seg, dp, dig_sel, frame_done, frame_err, dbg_state);
      end
      @(negedge osc_in) cdiv_rst = 1'b0;
      base = done_cnt;
      for (int i = 0; i < 30; i++) send_tick(1'b0, 5'h08);
      n_checks++;
      if (done_cnt !== base || frame_err !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL midreset_after done=%0d err=%b st=%0d required 0 0 0",
                  done_cnt - base, frame_err, dbg_state);
      end
      for (int i = 0; i < 14; i++) begin exp_seg[i] = 7'h00; exp_dp[i] = 1'b0; end
      check_scan("midreset_blank");
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_scan_timing();
      test_abort();
      test_display_en();
      test_reset_mid_capture();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
